// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one bit per clock; SERIAL_ADDER_SUB_EN adds the sub port for a - b
module serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carry
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sa, sb, sr_n;
  logic [WIDTH-2:0] sr;
  logic [CW-1:0] cnt;
  logic c, s, c_n, last, neg;
`ifdef SERIAL_ADDER_SUB_EN
  assign neg = sub;
`else
  assign neg = 1'b0;
`endif
  always_comb begin
    s = sa[0] ^ sb[0] ^ c;
    c_n = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
    sr_n = {s, sr};
    last = cnt == CW'(WIDTH - 1);
    state_n = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
    busy = state == RUN;
    done = state == DONE;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      sa <= '0;
      sb <= '0;
      sr <= '0;
      c <= 1'b0;
      cnt <= '0;
      out <= '0;
      carry <= 1'b0;
    end else if (state == IDLE && start) begin
      sa <= a;
      sb <= neg ? ~b : b;
      c <= neg;
      cnt <= '0;
    end else if (state == RUN) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      sr <= sr_n[WIDTH-1:1];
      c <= c_n;
      cnt <= cnt + 1'b1;
      if (last) begin
        out <= sr_n;
        carry <= c_n;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder timing, add, subtract, hold and reset abort
module tb_serial_adder;
  localparam int W = 16;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, sub = 1'b0;
  logic [W-1:0] a = '0, b = '0, out;
  logic busy, done, carry;
  int vectors = 0, miscompares = 0;
  logic [W:0] sbq[$];
  logic [W:0] last = '0;
  always #5 clk = ~clk;
  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .out(out), .carry(carry)
  );
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input bit hold, input bit chg);
    logic [W:0] exp;
    a = x;
    b = y;
    sub = s;
    start = 1'b1;
    sbq.push_back(s ? {1'b0, x} + {1'b0, ~y} + (W+1)'(1) : {1'b0, x} + {1'b0, y});
    @(posedge clk);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (chg) begin
        a = '1;
        b = '1;
        sub = ~s;
      end
      vectors++;
      if ({busy, done, carry, out} !== {2'b10, last}) begin
        miscompares++;
        $display("FAIL run_cycle%0d op %h+%h: busy=%b done=%b carry=%b out=%h, expected busy=1 done=0 carry=%b out=%h",
                 i, x, y, busy, done, carry, out, last[W], last[W-1:0]);
      end
    end
    @(negedge clk);
    vectors++;
    if (sbq.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty op %h+%h", x, y);
      exp = '0;
    end else exp = sbq.pop_front();
    if ({busy, done, carry, out} !== {2'b01, exp}) begin
      miscompares++;
      $display("FAIL done_cycle op %h+%h: busy=%b done=%b carry=%b out=%h, expected busy=0 done=1 carry=%b out=%h",
               x, y, busy, done, carry, out, exp[W], exp[W-1:0]);
    end
    last = exp;
    @(negedge clk);
    vectors++;
    if ({busy, done, carry, out} !== {2'b00, last}) begin
      miscompares++;
      $display("FAIL after_done op %h+%h: busy=%b done=%b carry=%b out=%h, expected busy=0 done=0 carry=%b out=%h",
               x, y, busy, done, carry, out, last[W], last[W-1:0]);
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, carry, out} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b carry=%b out=%h, expected all 0", busy, done, carry, out);
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_no_start: busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask
  task automatic test_add;
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
    run_op(16'hA5C3, 16'h7E19, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_back_to_back;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b1, 1'b1);
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_reset_abort;
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
    a = 16'h0F0F;
    b = 16'h0101;
    start = 1'b1;
    sbq.push_back({1'b0, a} + {1'b0, b});
    @(posedge clk);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 8) reset = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    sbq.delete();
    last = '0;
    vectors++;
    if ({busy, done, carry, out} !== '0) begin
      miscompares++;
      $display("FAIL abort_state: busy=%b done=%b carry=%b out=%h, expected all 0", busy, done, carry, out);
    end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      vectors++;
      if ({busy, done, carry, out} !== '0) begin
        miscompares++;
        $display("FAIL abort_quiet%0d: busy=%b done=%b carry=%b out=%h, expected all 0", i, busy, done, carry, out);
      end
    end
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0);
  endtask
`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0);
    run_op(16'h0007, 16'h0005, 1'b1, 1'b0, 1'b0);
    run_op(16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0);
  endtask
`endif
  task automatic test_hold;
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'h1111, 16'h1111, 1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_reset_abort();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
